// File: rtl/ctrl_ramdrv_coefload_pkg.sv
// Shared definitions for the coefficient-load controller: state encoding,
// default widths and a debug helper for printing state names.
`ifndef CTRL_RAMDRV_COEFLOAD_PKG_SV
`define CTRL_RAMDRV_COEFLOAD_PKG_SV

package ctrl_ramdrv_coefload_pkg;

    // Default coefficient RAM geometry
    localparam int CL_ADDR_WIDTH = 12;
    localparam int CL_COEF_WIDTH = 16;

    // Load-session controller states
    typedef enum logic [1:0] {
        CL_IDLE  = 2'b00,
        CL_WRITE = 2'b01,
        CL_FIN   = 2'b10
    } cl_state_e;

endpackage

// Debug helper: ASCII name of a cl_state_e value for simulation messages.
`define CL_STATE_NAME(st) (((st) == ctrl_ramdrv_coefload_pkg::CL_IDLE)  ? "IDLE"  : \
                           ((st) == ctrl_ramdrv_coefload_pkg::CL_WRITE) ? "WRITE" : \
                           ((st) == ctrl_ramdrv_coefload_pkg::CL_FIN)   ? "FIN"   : "BAD")

`endif

// File: rtl/ctrl_ramdrv_coefload_addrgen.sv
// Write-address counter for the coefficient loader. Loads the session base
// pointer, steps by one per accepted beat and flags the step that wraps from
// the top of the address space back to zero.
module ctrl_coefload_addrgen
    import ctrl_ramdrv_coefload_pkg::*;
#(
    parameter int ADDR_WIDTH = CL_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_load,
    input  logic [ADDR_WIDTH-1:0] i_load_val,
    input  logic                  i_inc,
    output logic [ADDR_WIDTH-1:0] o_addr,
    output logic                  o_wrap
);

    logic [ADDR_WIDTH-1:0] r_addr;

    // Address register: load has priority over increment; otherwise hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr <= {ADDR_WIDTH{1'b0}};
        end else if (i_load) begin
            r_addr <= i_load_val;
        end else if (i_inc) begin
            r_addr <= r_addr + ADDR_WIDTH'(1);
        end else begin
            r_addr <= r_addr;
        end
    end

    assign o_addr = r_addr;
    // The increment leaving the all-ones address is the one that wraps.
    assign o_wrap = i_inc & (&r_addr);

endmodule

// File: rtl/ctrl_ramdrv_coefload.sv
// Coefficient RAM loader: takes a load command (base, count), then writes a
// valid/ready stream of coefficients to consecutive RAM addresses, one cycle
// after each accepted beat. Acceptance stalls while the read side owns the RAM.
module ctrl_ramdrv_coefload
    import ctrl_ramdrv_coefload_pkg::*;
#(
    parameter int ADDR_WIDTH = CL_ADDR_WIDTH,
    parameter int COEF_WIDTH = CL_COEF_WIDTH,
    parameter int LEN_WIDTH  = ADDR_WIDTH + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_ptr,
    input  logic [LEN_WIDTH-1:0]  length,
    input  logic                  abort,
    input  logic                  s_valid,
    input  logic [COEF_WIDTH-1:0] s_data,
    output logic                  s_ready,
    input  logic                  rd_busy,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_waddr,
    output logic [COEF_WIDTH-1:0] ram_wdata,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [LEN_WIDTH-1:0]  wr_count
);

    cl_state_e             r_state;
    cl_state_e             w_state_nxt;

    logic                  w_s_ready;
    logic                  w_accept;
    logic                  w_last;
    logic                  w_start_go;
    logic                  w_start_zero;
    logic                  w_abort_go;

    logic [ADDR_WIDTH-1:0] w_addr;
    logic                  w_wrap;

    logic [LEN_WIDTH-1:0]  r_remaining;
    logic                  r_ram_we;
    logic [ADDR_WIDTH-1:0] r_ram_waddr;
    logic [COEF_WIDTH-1:0] r_ram_wdata;
    logic                  r_done;
    logic                  r_err;
    logic [LEN_WIDTH-1:0]  r_wr_count;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= CL_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic, stream handshake and session control strobes.
    always_comb begin
        w_state_nxt  = r_state;
        w_s_ready    = 1'b0;
        w_accept     = 1'b0;
        w_last       = 1'b0;
        w_start_go   = 1'b0;
        w_start_zero = 1'b0;
        w_abort_go   = 1'b0;
        case (r_state)
            CL_IDLE: begin
                if (start) begin
                    if (length != {LEN_WIDTH{1'b0}}) begin
                        w_start_go  = 1'b1;
                        w_state_nxt = CL_WRITE;
                    end else begin
                        w_start_zero = 1'b1;
                        w_state_nxt  = CL_IDLE;
                    end
                end else begin
                    w_state_nxt = CL_IDLE;
                end
            end
            CL_WRITE: begin
                // An abort cycle never accepts a beat; read ownership stalls.
                w_s_ready = !rd_busy && !abort;
                w_accept  = w_s_ready && s_valid;
                w_last    = w_accept && (r_remaining == LEN_WIDTH'(1));
                if (abort) begin
                    w_abort_go  = 1'b1;
                    w_state_nxt = CL_IDLE;
                end else if (w_last) begin
                    w_state_nxt = CL_FIN;
                end else begin
                    w_state_nxt = CL_WRITE;
                end
            end
            CL_FIN: begin
                w_state_nxt = CL_IDLE;
            end
            default: begin
                w_state_nxt = CL_IDLE;
            end
        endcase
    end

    ctrl_coefload_addrgen #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_addrgen (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_start_go),
        .i_load_val (base_ptr),
        .i_inc      (w_accept),
        .o_addr     (w_addr),
        .o_wrap     (w_wrap)
    );

    // Remaining-beat counter: loaded at session start, one down per beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_remaining <= {LEN_WIDTH{1'b0}};
        end else if (w_start_go) begin
            r_remaining <= length;
        end else if (w_accept) begin
            r_remaining <= r_remaining - LEN_WIDTH'(1);
        end else begin
            r_remaining <= r_remaining;
        end
    end

    // RAM write port: the beat accepted this cycle is written next cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ram_we    <= 1'b0;
            r_ram_waddr <= {ADDR_WIDTH{1'b0}};
            r_ram_wdata <= {COEF_WIDTH{1'b0}};
        end else if (w_accept) begin
            r_ram_we    <= 1'b1;
            r_ram_waddr <= w_addr;
            r_ram_wdata <= s_data;
        end else begin
            r_ram_we    <= 1'b0;
            r_ram_waddr <= r_ram_waddr;
            r_ram_wdata <= r_ram_wdata;
        end
    end

    // Completion pulse: lines up with the final write (FIN) or, for an
    // empty load, appears the cycle after the start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_done <= 1'b0;
        end else begin
            r_done <= w_last || w_start_zero;
        end
    end

    // Sticky error: cleared by an accepted start, set by wrap or abort.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (w_start_go || w_start_zero) begin
            r_err <= 1'b0;
        end else if (w_abort_go || (w_accept && w_wrap)) begin
            r_err <= 1'b1;
        end else begin
            r_err <= r_err;
        end
    end

    // Words-written counter: cleared by an accepted start, held afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_count <= {LEN_WIDTH{1'b0}};
        end else if (w_start_go || w_start_zero) begin
            r_wr_count <= {LEN_WIDTH{1'b0}};
        end else if (w_accept) begin
            r_wr_count <= r_wr_count + LEN_WIDTH'(1);
        end else begin
            r_wr_count <= r_wr_count;
        end
    end

    assign s_ready   = w_s_ready;
    assign busy      = (r_state != CL_IDLE);
    assign ram_we    = r_ram_we;
    assign ram_waddr = r_ram_waddr;
    assign ram_wdata = r_ram_wdata;
    assign done      = r_done;
    assign err       = r_err;
    assign wr_count  = r_wr_count;

endmodule

// File: tb/tb_ctrl_ramdrv_coefload.sv
// Bench for the coefficient loader: a session-level reference model predicts
// RAM writes and completion pulses into queues; a monitor pops and compares
// whenever the DUT writes or signals done.
module tb_ctrl_ramdrv_coefload;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [11:0] base_ptr = 12'h000;
    logic [12:0] length = 13'h0000;
    logic        abort = 1'b0;
    logic        s_valid = 1'b0;
    logic [15:0] s_data = 16'h0000;
    logic        s_ready;
    logic        rd_busy = 1'b0;
    logic        ram_we;
    logic [11:0] ram_waddr;
    logic [15:0] ram_wdata;
    logic        busy;
    logic        done;
    logic        err;
    logic [12:0] wr_count;

    typedef struct { int a; int d; } wr_t;
    typedef struct { bit e; bit w; int c; } dn_t;

    wr_t wq[$];
    dn_t dq[$];

    int n_checks = 0;
    int n_errors = 0;

    // Reference model of the load session, in plain arithmetic
    bit m_active = 1'b0;
    bit m_fin    = 1'b0;
    bit m_err    = 1'b0;
    int m_addr   = 0;
    int m_rem    = 0;
    int m_cnt    = 0;

    ctrl_ramdrv_coefload dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .base_ptr  (base_ptr),
        .length    (length),
        .abort     (abort),
        .s_valid   (s_valid),
        .s_data    (s_data),
        .s_ready   (s_ready),
        .rd_busy   (rd_busy),
        .ram_we    (ram_we),
        .ram_waddr (ram_waddr),
        .ram_wdata (ram_wdata),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .wr_count  (wr_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_s_ready"},   int'(s_ready),   0);
        chk({tag, "_ram_we"},    int'(ram_we),    0);
        chk({tag, "_ram_waddr"}, int'(ram_waddr), 0);
        chk({tag, "_ram_wdata"}, int'(ram_wdata), 0);
        chk({tag, "_busy"},      int'(busy),      0);
        chk({tag, "_done"},      int'(done),      0);
        chk({tag, "_err"},       int'(err),       0);
        chk({tag, "_wr_count"},  int'(wr_count),  0);
    endtask

    task automatic apply_reset(input string tag);
        @(negedge clk);
        rst_n = 1'b0;
        start = 1'b0; abort = 1'b0; s_valid = 1'b0; rd_busy = 1'b0;
        #1;
        chk_all_zero(tag);
        m_active = 1'b0; m_fin = 1'b0; m_err = 1'b0;
        m_addr = 0; m_rem = 0; m_cnt = 0;
        wq.delete();
        dq.delete();
        repeat (2) @(negedge clk);
        #1;
        chk_all_zero({tag, "_hold"});
        rst_n = 1'b1;
    endtask

    // One clock of stimulus: drive inputs, check the handshake and status
    // against the model, then advance the model by the effect of this cycle.
    task automatic cycle(input bit st, input logic [11:0] b, input logic [12:0] l,
                         input bit v, input logic [15:0] d, input bit rb, input bit ab);
        bit  exp_rdy;
        bit  nfin;
        wr_t w;
        dn_t dn;
        @(negedge clk);
        start = st; base_ptr = b; length = l;
        s_valid = v; s_data = d; rd_busy = rb; abort = ab;
        #1;
        exp_rdy = m_active && !rb && !ab;
        chk("s_ready",  int'(s_ready),  int'(exp_rdy));
        chk("busy",     int'(busy),     int'(m_active || m_fin));
        chk("err",      int'(err),      int'(m_err));
        chk("wr_count", int'(wr_count), m_cnt);
        nfin = 1'b0;
        if (m_active) begin
            if (ab) begin
                m_active = 1'b0;
                m_err    = 1'b1;
            end else if (exp_rdy && v) begin
                w.a = m_addr;
                w.d = int'(d);
                wq.push_back(w);
                if (m_addr == 4095) m_err = 1'b1;
                m_addr = (m_addr + 1) % 4096;
                m_cnt++;
                m_rem--;
                if (m_rem == 0) begin
                    m_active = 1'b0;
                    nfin     = 1'b1;
                    dn.e = m_err; dn.w = 1'b1; dn.c = m_cnt;
                    dq.push_back(dn);
                end
            end
        end else if (!m_fin && st) begin
            m_err = 1'b0;
            m_cnt = 0;
            if (l != 13'd0) begin
                m_active = 1'b1;
                m_addr   = int'(b);
                m_rem    = int'(l);
            end else begin
                dn.e = 1'b0; dn.w = 1'b0; dn.c = 0;
                dq.push_back(dn);
            end
        end
        m_fin = nfin;
    endtask

    task automatic idle_cycle();
        cycle(1'b0, 12'h000, 13'd0, 1'b0, 16'h0000, 1'b0, 1'b0);
    endtask

    // A whole session: start, then beats with the given valid / read-busy
    // percentages, an optional forced stall window (session-relative beat
    // slots), optional abort after abort_at beats, optional stray starts.
    task automatic run_session(input logic [11:0] b, input logic [12:0] l,
                               input int vpct, input int bpct,
                               input int stall_lo, input int stall_hi,
                               input int abort_at, input bit noise);
        int k;
        bit v, rb, ab, st;
        cycle(1'b1, b, l, 1'b0, 16'h0000, 1'b0, 1'b0);
        k = 0;
        while ((m_active || m_fin) && k < 3000) begin
            v  = (int'($urandom_range(99)) < vpct);
            rb = (int'($urandom_range(99)) < bpct);
            if (k >= stall_lo && k <= stall_hi) rb = 1'b1;
            ab = m_fin ? 1'($urandom_range(1)) : (abort_at >= 0 && m_cnt == abort_at);
            st = noise && ($urandom_range(3) == 0);
            cycle(st, 12'($urandom), 13'($urandom_range(20)), v, 16'($urandom), rb, ab);
            k++;
        end
        if (k >= 3000) chk("session_timeout", 1, 0);
        idle_cycle();
    endtask

    // Monitor: compare every RAM write and every done pulse with the model.
    initial begin
        wr_t e;
        dn_t dn;
        forever begin
            @(posedge clk);
            #1;
            if (ram_we) begin
                if (wq.size() == 0) begin
                    chk("spurious_write", 1, 0);
                end else begin
                    e = wq.pop_front();
                    chk("ram_waddr", int'(ram_waddr), e.a);
                    chk("ram_wdata", int'(ram_wdata), e.d);
                end
            end
            if (done) begin
                if (dq.size() == 0) begin
                    chk("spurious_done", 1, 0);
                end else begin
                    dn = dq.pop_front();
                    chk("done_ram_we",   int'(ram_we),   int'(dn.w));
                    chk("done_err",      int'(err),      int'(dn.e));
                    chk("done_wr_count", int'(wr_count), dn.c);
                end
            end
        end
    end

    // Global time limit so the run always ends.
    initial begin
        #5000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int len;
        logic [11:0] b;
        apply_reset("rst_init");

        // Reset mid-session at address 0x005
        cycle(1'b1, 12'h003, 13'd8, 1'b0, 16'h0000, 1'b0, 1'b0);
        cycle(1'b0, 12'h000, 13'd0, 1'b1, 16'hA001, 1'b0, 1'b0);
        cycle(1'b0, 12'h000, 13'd0, 1'b1, 16'hA002, 1'b0, 1'b0);
        apply_reset("rst_mid");

        // Plain four-word load
        run_session(12'h010, 13'd4, 100, 0, -1, -1, -1, 1'b0);
        // Address wrap across the top of the RAM
        run_session(12'hFFE, 13'd4, 100, 0, -1, -1, -1, 1'b0);
        // Read side holds the RAM for session cycles 2-5
        run_session(12'h020, 13'd4, 100, 0, 0, 3, -1, 1'b0);
        // Abort after three accepted beats
        run_session(12'h040, 13'd8, 100, 0, -1, -1, 3, 1'b0);
        idle_cycle();
        // Empty load, then stray starts during an active session
        cycle(1'b1, 12'h055, 13'd0, 1'b0, 16'h0000, 1'b0, 1'b0);
        idle_cycle();
        idle_cycle();
        run_session(12'h100, 13'd6, 100, 0, -1, -1, -1, 1'b1);

        // Randomized sessions
        for (int i = 0; i < 40; i++) begin
            b   = ($urandom_range(3) == 0) ? (12'hFF0 + 12'($urandom_range(15))) : 12'($urandom);
            len = ($urandom_range(9) == 0) ? 0 : int'($urandom_range(24, 1));
            if (len == 0) begin
                cycle(1'b1, b, 13'd0, 1'b0, 16'h0000, 1'b0, 1'b0);
                idle_cycle();
            end else begin
                run_session(b, 13'(len), int'($urandom_range(100, 40)), int'($urandom_range(40)),
                            -1, -1,
                            ($urandom_range(4) == 0) ? int'($urandom_range(len - 1)) : -1,
                            1'b1);
            end
            idle_cycle();
        end

        idle_cycle();
        idle_cycle();
        chk("pending_writes", wq.size(), 0);
        chk("pending_done",   dq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ctrl_ramdrv_coefload.md
Name: ctrl_ramdrv_coefload

Overview:
Write-side companion to the coefficient read-address counter. It accepts a load command (base pointer and word count), then takes a valid/ready stream of filter coefficients and writes them into the coefficient RAM at consecutive addresses. It sits between the host/config interface and the coefficient RAM write port in the controller. It stalls while the read path is using the RAM.

Parameters:
ADDR_WIDTH, 12, coefficient RAM address width
COEF_WIDTH, 16, coefficient word width
LEN_WIDTH, ADDR_WIDTH+1, width of the word-count field (allows a full 2^ADDR_WIDTH load)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous, active-low reset
start  in  1  load-session request, sampled in IDLE only
base_ptr  in  ADDR_WIDTH  first RAM address of the session
length  in  LEN_WIDTH  number of coefficients to write
abort  in  1  cancel the active session
s_valid  in  1  coefficient valid
s_data  in  COEF_WIDTH  coefficient word
s_ready  out  1  coefficient accepted when s_valid && s_ready
rd_busy  in  1  read side owns the RAM; stalls acceptance
ram_we  out  1  RAM write enable
ram_waddr  out  ADDR_WIDTH  RAM write address
ram_wdata  out  COEF_WIDTH  RAM write data
busy  out  1  session active
done  out  1  one-cycle pulse on normal completion
err  out  1  sticky error flag; cleared by the next accepted start
wr_count  out  LEN_WIDTH  words written in the current or last session

Behaviour:
- Reset (async, rst_n=0): state IDLE. All outputs are 0: s_ready, ram_we, ram_waddr, ram_wdata, busy, done, err, wr_count. RAM writes stop immediately, including mid-session.
- FSM states: IDLE, WRITE, FIN.
- IDLE, start=1, length!=0:
  - Latch base_ptr into the address counter and length into the remaining counter.
  - Clear err and wr_count.
  - Next state WRITE.
- IDLE, start=1, length=0: no RAM write, err cleared, done=1 in the next cycle, stay IDLE.
- start outside IDLE is ignored.
- WRITE:
  - s_ready = !rd_busy && !abort. This is combinational from registered state and the two inputs.
  - Beat accepted in cycle N: in cycle N+1, ram_we=1, ram_waddr=current address, ram_wdata=s_data(N).
  - On each accepted beat the address increments by 1, remaining decrements, wr_count increments.
  - Latency from accept to RAM write is exactly 1 cycle. ram_we=0 in every cycle not following an accept.
- Address wrap: an increment from 2^ADDR_WIDTH-1 wraps to 0, sets err (sticky), and the session continues.
- Last beat (remaining==1 at accept): next state FIN.
- FIN:
  - Lasts one cycle. done=1, busy=1, and the final ram_we=1 in this same cycle.
  - s_ready=0.
  - Next state IDLE.
- busy=1 in WRITE and FIN, 0 in IDLE.
- abort in WRITE:
  - No beat is accepted in that cycle. The next state is IDLE, err=1, and no done pulse.
  - A beat accepted in the previous cycle still completes its RAM write.
- abort in IDLE or FIN: ignored.
- rd_busy held high: the session stalls indefinitely with no timeout. Address and counters hold.
- s_valid dropping mid-session: the block waits. Gaps between beats are allowed.
- wr_count holds its final value in IDLE until the next accepted start.

Decomposition:
- Shared controller package/header holds:
  - state encodings CL_IDLE=2'b00, CL_WRITE=2'b01, CL_FIN=2'b10;
  - the default ADDR_WIDTH and COEF_WIDTH constants;
  - the DEBUG ASCII state-name macro.
- Sub-module ctrl_coefload_addrgen:
  - load/inc address counter with wrap-detect output;
  - async active-low reset;
  - instantiated once.

Test Plan:
1. Reset with rst_n=0 mid-WRITE at address 0x005 -> in the same cycle ram_we=0, busy=0, s_ready=0, and all outputs 0 until release.
2. start, base_ptr=0x010, length=4, s_valid held 1, rd_busy=0 -> ram_we in 4 consecutive cycles at 0x010..0x013 with matching data; done=1 together with the 0x013 write; wr_count=4; err=0.
3. base_ptr=0xFFE, length=4 -> writes to 0xFFE, 0xFFF, 0x000, 0x001; err=1 after the wrap; done still pulses.
4. length=4, rd_busy=1 for cycles 2-5 of the session -> s_ready=0 and no ram_we during the stall; writes resume at the next address; total 4 writes, in order.
5. length=8, abort asserted after 3 accepted beats -> 3 RAM writes, busy falls the next cycle, err=1, done never asserted, wr_count=3.
6. start with length=0 -> done=1 one cycle later, no ram_we, busy stays 0; start pulsed during an active session -> ignored, counters unchanged.
